// File: rtl/booth_arb_pkg.sv
// Shared types and width helpers for the Booth multiplier arbiter.
// Holds the FSM state encoding and the functions that size id/product buses.
package booth_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int y_width(input int area);
    return 2 * area;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping around the vector.
module arb_rr_pick import booth_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  grant
);

  // Scan from the farthest candidate back towards ptr so the nearest one wins.
  always_comb begin
    int idx;
    any   = |req;
    grant = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) grant = idx[IDW-1:0];
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one Booth multiplier among NREQ requesters.
// Optional wait timeout is enabled with the BOOTH_ARB_TIMEOUT_EN macro.
module booth_mult_arbiter import booth_arb_pkg::*; #(
  parameter int AREA          = 4,
  parameter int NREQ          = 4,
  parameter int TIMEOUT_LIMIT = 64,
  localparam int IDW          = id_width(NREQ),
  localparam int YW           = y_width(AREA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AREA-1:0] req_a,
  input  logic [NREQ*AREA-1:0] req_b,
  output logic [NREQ-1:0]      req_ack,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [YW-1:0]        resp_y,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 mult_start,
  output logic [AREA-1:0]      mult_a,
  output logic [AREA-1:0]      mult_b,
  input  logic                 mult_done,
  input  logic [YW-1:0]        mult_y
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           wait_armed;
  logic           capture;
  logic           timeout_hit;

  arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .grant (pick_idx)
  );

  // A done seen in the first WAIT cycle may belong to the previous operation.
  assign capture = (state == WAIT) && wait_armed && mult_done;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_LIMIT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !capture &&
                       (wait_cnt == CW'(TIMEOUT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  // TIMEOUT_LIMIT only matters when the timeout is built in.
  localparam bit unused_timeout_limit = (TIMEOUT_LIMIT > 0);
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    req_ack    = '0;
    mult_start = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        mult_start       = 1'b1;
        req_ack[grant_q] = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (capture || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched only at arbitration, so they stay put for the whole op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      wait_armed <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_y     <= '0;
      resp_id    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            mult_a  <= req_a[pick_idx*AREA +: AREA];
            mult_b  <= req_b[pick_idx*AREA +: AREA];
          end
        end
        ISSUE: begin
          wait_armed <= 1'b0;
          rr_ptr     <= (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
        WAIT: begin
          wait_armed <= 1'b1;
          if (capture) begin
            resp_y  <= mult_y;
            resp_id <= grant_q;
          end else if (timeout_hit) begin
            resp_y  <= '0;
            resp_id <= grant_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed self-checking bench for booth_mult_arbiter with a simple multiplier model.
// Timeout scenario is included when BOOTH_ARB_TIMEOUT_EN is defined.
module tb_booth_mult_arbiter;

  localparam int AREA = 4;
  localparam int NREQ = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ack;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_y;
  logic        resp_err;
  logic        busy;
  logic        mult_start;
  logic [3:0]  mult_a;
  logic [3:0]  mult_b;
  logic        mult_done;
  logic [7:0]  mult_y;

  logic        model_en;
  logic        stale_done;
  int          mult_lat;
  int          model_cnt;
  logic        model_done;
  logic [7:0]  model_y;

  int          errors;
  int          checks;
  int          starts;
  int          ack_q[$];
  logic [1:0]  rid_q[$];
  logic [7:0]  ry_q[$];

  booth_mult_arbiter #(.AREA(AREA), .NREQ(NREQ), .TIMEOUT_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ack    (req_ack),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_err   (resp_err),
    .busy       (busy),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_done  (mult_done),
    .mult_y     (mult_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stand-in: done pulses mult_lat cycles after a start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
      model_y    <= '0;
    end else begin
      model_done <= 1'b0;
      if (mult_start && model_en) begin
        model_cnt <= mult_lat;
      end else if (model_cnt > 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) begin
          model_done <= 1'b1;
          model_y    <= {{4{mult_a[3]}}, mult_a} * {{4{mult_b[3]}}, mult_b};
        end
      end
    end
  end

  assign mult_done = model_done | stale_done;
  assign mult_y    = stale_done ? 8'hAA : model_y;

  task automatic step(input bit drop);
    @(posedge clk);
    #1;
    if (mult_start) starts++;
    for (int i = 0; i < NREQ; i++) if (req_ack[i]) ack_q.push_back(i);
    if (resp_valid) begin
      rid_q.push_back(resp_id);
      ry_q.push_back(resp_y);
    end
    if (drop) req_valid = req_valid & ~req_ack;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_q.delete();
    rid_q.delete();
    ry_q.delete();
    starts = 0;
  endtask

  task automatic wait_resp(input int maxc, output bit got);
    got = 1'b0;
    for (int n = 0; n < maxc && !got; n++) begin
      step(1'b1);
      if (resp_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL resp_wait: no resp_valid within %0d cycles", maxc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    while (busy && n < 50) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, resp_valid, mult_start, req_ack} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {busy, resp_valid, mult_start, req_ack});
    end
    checks++;
    if ({mult_a, mult_b} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_operands: got %h expected 00", {mult_a, mult_b});
    end
    checks++;
    if ({resp_err, resp_id, resp_y} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got %h expected 000", {resp_err, resp_id, resp_y});
    end
  endtask

  task automatic test_single();
    bit got;
    do_reset();
    req_a     = 16'h000D;
    req_b     = 16'h0005;
    req_valid = 4'b0001;
    step(1'b1);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_ack: got %b expected 0001", req_ack);
    end
    checks++;
    if ({mult_start, mult_a, mult_b} !== 9'b1_1101_0101) begin
      errors++;
      $display("[TB] FAIL single_issue: got %b expected 111010101", {mult_start, mult_a, mult_b});
    end
    wait_resp(50, got);
    if (got) begin
      checks++;
      if ({resp_id, resp_y} !== {2'd0, 8'hF1}) begin
        errors++;
        $display("[TB] FAIL single_result: got id=%0d y=%h expected id=0 y=f1", resp_id, resp_y);
      end
    end
    step(1'b1);
    checks++;
    if ({resp_valid, resp_y} !== {1'b0, 8'hF1}) begin
      errors++;
      $display("[TB] FAIL single_hold: got valid=%b y=%h expected valid=0 y=f1", resp_valid, resp_y);
    end
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("[TB] FAIL single_starts: got %0d expected 1", starts);
    end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_y[4];
    int n;
    exp_y = '{8'h06, 8'hFA, 8'h31, 8'h40};
    do_reset();
    req_a     = {4'h8, 4'h7, 4'hE, 4'h2};
    req_b     = {4'h8, 4'h7, 4'h3, 4'h3};
    req_valid = 4'b1111;
    n = 0;
    while (rid_q.size() < 4 && n < 200) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (rid_q.size() != 4 || ack_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL all4_count: got acks=%0d resps=%0d expected 4 and 4", ack_q.size(), rid_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_q[i] != i || rid_q[i] !== 2'(i) || ry_q[i] !== exp_y[i]) begin
          errors++;
          $display("[TB] FAIL all4_txn%0d: got ack=%0d id=%0d y=%h expected ack=%0d id=%0d y=%h",
                   i, ack_q[i], rid_q[i], ry_q[i], i, i, exp_y[i]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int exp_g[4];
    int n;
    exp_g = '{1, 3, 1, 3};
    do_reset();
    req_a     = {4'h1, 4'h0, 4'h2, 4'h0};
    req_b     = {4'h1, 4'h0, 4'h2, 4'h0};
    req_valid = 4'b1010;
    n = 0;
    while (ack_q.size() < 4 && n < 300) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (ack_q.size() < 4) begin
      errors++;
      $display("[TB] FAIL fair_count: got %0d acks expected 4", ack_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_q[i] != exp_g[i]) begin
          errors++;
          $display("[TB] FAIL fair_grant%0d: got %0d expected %0d", i, ack_q[i], exp_g[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_stale_done();
    bit got;
    do_reset();
    req_a     = 16'h0300;
    req_b     = 16'h0E00;
    req_valid = 4'b0100;
    step(1'b1);
    checks++;
    if (req_ack !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL stale_ack: got %b expected 0100", req_ack);
    end
    stale_done = 1'b1;
    step(1'b1);
    step(1'b1);
    stale_done = 1'b0;
    checks++;
    if ({resp_valid, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stale_masked: got valid=%b busy=%b expected valid=0 busy=1", resp_valid, busy);
    end
    wait_resp(50, got);
    if (got) begin
      checks++;
      if ({resp_id, resp_y} !== {2'd2, 8'hFA}) begin
        errors++;
        $display("[TB] FAIL stale_result: got id=%0d y=%h expected id=2 y=fa", resp_id, resp_y);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    do_reset();
    req_a     = 16'h0005;
    req_b     = 16'h0003;
    req_valid = 4'b0001;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, resp_valid, mult_start, req_ack, mult_a, mult_b, resp_y} !== 23'b0) begin
      errors++;
      $display("[TB] FAIL midwait_async: got busy=%b ack=%b a=%h b=%h y=%h expected all 0",
               busy, req_ack, mult_a, mult_b, resp_y);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rid_q.delete();
    ack_q.delete();
    for (int i = 0; i < 10; i++) step(1'b1);
    checks++;
    if (rid_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL midwait_noresp: got %0d responses expected 0", rid_q.size());
    end
    req_a     = 16'h1002;
    req_b     = 16'h1002;
    req_valid = 4'b1001;
    step(1'b1);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midwait_rrptr: got %b expected 0001", req_ack);
    end
    wait_resp(50, got);
    if (got) begin
      checks++;
      if ({resp_id, resp_y} !== {2'd0, 8'h04}) begin
        errors++;
        $display("[TB] FAIL midwait_result: got id=%0d y=%h expected id=0 y=04", resp_id, resp_y);
      end
    end
    drain();
  endtask

`ifdef BOOTH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    do_reset();
    req_a     = 16'h0200;
    req_b     = 16'h0300;
    req_valid = 4'b0100;
    wait_resp(50, got);
    if (got) begin
      checks++;
      if ({resp_err, resp_y} !== {1'b0, 8'h06}) begin
        errors++;
        $display("[TB] FAIL to_pre: got err=%b y=%h expected err=0 y=06", resp_err, resp_y);
      end
    end
    drain();
    model_en  = 1'b0;
    req_a     = 16'h0020;
    req_b     = 16'h0020;
    req_valid = 4'b0010;
    step(1'b1);
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL to_ack: got %b expected 0010", req_ack);
    end
    for (int i = 0; i < 8; i++) step(1'b1);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_early: got valid=%b expected 0", resp_valid);
    end
    step(1'b1);
    checks++;
    if ({resp_valid, resp_err, resp_id, resp_y} !== {1'b1, 1'b1, 2'd1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL to_resp: got valid=%b err=%b id=%0d y=%h expected valid=1 err=1 id=1 y=00",
               resp_valid, resp_err, resp_id, resp_y);
    end
    model_en = 1'b1;
    drain();
    req_a     = 16'hF000;
    req_b     = 16'h1000;
    req_valid = 4'b1000;
    wait_resp(50, got);
    if (got) begin
      checks++;
      if ({resp_err, resp_id, resp_y} !== {1'b0, 2'd3, 8'hFF}) begin
        errors++;
        $display("[TB] FAIL to_after: got err=%b id=%0d y=%h expected err=0 id=3 y=ff",
                 resp_err, resp_id, resp_y);
      end
    end
    drain();
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    starts     = 0;
    model_en   = 1'b1;
    stale_done = 1'b0;
    mult_lat   = 3;
    rst        = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_stale_done();
    test_reset_mid_wait();
`ifdef BOOTH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
